// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the two-source mux select arbiter.
package mux_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two sources and the arbiter.
interface mux_sel_arbiter_if;

    logic req_a;
    logic req_b;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic busy;
    logic switch;

    modport master (
        output req_a, req_b,
        input  sel, gnt_a, gnt_b, busy, switch
    );

    modport slave (
        input  req_a, req_b,
        output sel, gnt_a, gnt_b, busy, switch
    );

endinterface

// File: rtl/mux_1bit.sv
// Plain 1-bit 2:1 mux: x_i=0 passes a_i, x_i=1 passes b_i.
module mux_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic x_i,
    output logic y_o
);

    assign y_o = x_i ? b_i : a_i;

endmodule

// File: rtl/mux_arb_path.sv
// Integration wrapper: the arbiter steering a mux_1bit between two data sources.
module mux_arb_path #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic data_a_i,
    input  logic data_b_i,
    output logic data_y_o,
    output logic gnt_a_o,
    output logic gnt_b_o,
    output logic busy_o,
    output logic switch_o
);

    mux_sel_arbiter_if arb ();

    assign arb.req_a = req_a_i;
    assign arb.req_b = req_b_i;
    assign gnt_a_o   = arb.gnt_a;
    assign gnt_b_o   = arb.gnt_b;
    assign busy_o    = arb.busy;
    assign switch_o  = arb.switch;

    mux_sel_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb)
    );

    mux_1bit u_mux (
        .a_i (data_a_i),
        .b_i (data_b_i),
        .x_i (arb.sel),
        .y_o (data_y_o)
    );

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two requesters; every output comes straight from a flop.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux_sel_arbiter_if.slave arb
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_b_q, busy_q, switch_q;
    logic             entry;
    logic             contended;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb.req_a && arb.req_b)
                    state_d = (last_owner_q == SEL_A) ? ST_GNT_B : ST_GNT_A;
                else if (arb.req_a)
                    state_d = ST_GNT_A;
                else if (arb.req_b)
                    state_d = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (!arb.req_a)
                    state_d = arb.req_b ? ST_GNT_B : ST_IDLE;
                else if (arb.req_b && hold_cnt_q == HOLD_LAST)
                    state_d = ST_GNT_B;
            end
            ST_GNT_B: begin
                if (!arb.req_b)
                    state_d = arb.req_a ? ST_GNT_A : ST_IDLE;
                else if (arb.req_a && hold_cnt_q == HOLD_LAST)
                    state_d = ST_GNT_A;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant entry is any move into an owned state, from idle or by handover.
    always_comb begin
        entry        = (state_d != state_q) && (state_d != ST_IDLE);
        contended    = ((state_q == ST_GNT_A) && arb.req_b) ||
                       ((state_q == ST_GNT_B) && arb.req_a);
        hold_cnt_d   = '0;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        if (entry) begin
            sel_d        = (state_d == ST_GNT_B) ? SEL_B : SEL_A;
            last_owner_d = sel_d;
        end else if (contended) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= SEL_B;
            sel_q        <= SEL_A;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            switch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            sel_q        <= sel_d;
            gnt_a_q      <= (state_d == ST_GNT_A);
            gnt_b_q      <= (state_d == ST_GNT_B);
            busy_q       <= (state_d != ST_IDLE);
            switch_q     <= entry;
        end
    end

    assign arb.sel    = sel_q;
    assign arb.gnt_a  = gnt_a_q;
    assign arb.gnt_b  = gnt_b_q;
    assign arb.busy   = busy_q;
    assign arb.switch = switch_q;

endmodule
